// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - instruction/handshake and control-strobe bundle for multicycle_ctrl
interface multicycle_ctrl_if;
    logic [31:0] inst;
    logic        ALUZero;
    logic        mem_ready;
    logic        IRWrite;
    logic        PCWrite;
    logic [1:0]  PCsrc;
    logic [1:0]  InstType;
    logic        RegWrite;
    logic        ALUsrc;
    logic [2:0]  ALUop;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  MemtoReg;
    logic [2:0]  state;
    logic        illegal;
    logic [31:0] instret;

    modport master (
        input  inst, ALUZero, mem_ready,
        output IRWrite, PCWrite, PCsrc, InstType, RegWrite, ALUsrc, ALUop,
               MemRead, MemWrite, MemtoReg, state, illegal, instret
    );

    modport slave (
        output inst, ALUZero, mem_ready,
        input  IRWrite, PCWrite, PCsrc, InstType, RegWrite, ALUsrc, ALUop,
               MemRead, MemWrite, MemtoReg, state, illegal, instret
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle RV64-subset control FSM with illegal trap and retire counter
module multicycle_ctrl #(
    // opcodes packed LSB-first: ld, sd, R, addi, branch, jal, jalr
    parameter logic [48:0] FIELD_OPCODES = {7'b1100111, 7'b1101111, 7'b1100011,
                                            7'b0010011, 7'b0110011, 7'b0100011,
                                            7'b0000011}
) (
    input  logic clk,
    input  logic nrst,
    multicycle_ctrl_if.master bus
);
    localparam logic [6:0] OP_LD   = FIELD_OPCODES[6:0];
    localparam logic [6:0] OP_SD   = FIELD_OPCODES[13:7];
    localparam logic [6:0] OP_R    = FIELD_OPCODES[20:14];
    localparam logic [6:0] OP_ADDI = FIELD_OPCODES[27:21];
    localparam logic [6:0] OP_BR   = FIELD_OPCODES[34:28];
    localparam logic [6:0] OP_JAL  = FIELD_OPCODES[41:35];
    localparam logic [6:0] OP_JALR = FIELD_OPCODES[48:42];

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXEC    = 3'd2,
        MEM     = 3'd3,
        WB      = 3'd4,
        ILLEGAL = 3'd7
    } state_t;

    state_t      state_q, state_d;
    logic        illegal_q;
    logic [31:0] instret_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_ld, is_sd, is_r, is_addi, is_br, is_jal, is_jalr;
    logic       r_legal, legal, taken;
    logic [2:0] r_aop;
    logic       alu_src;
    logic [2:0] alu_op;
    logic [1:0] inst_type;
    logic       unused_inst;

    logic       ir_write, pc_write, reg_write, mem_read, mem_write;
    logic [1:0] pc_src, mem_to_reg;
    logic       o_alu_src;
    logic [2:0] o_alu_op;
    logic [1:0] o_inst_type;

    assign opcode      = bus.inst[6:0];
    assign funct3      = bus.inst[14:12];
    assign funct7      = bus.inst[31:25];
    assign unused_inst = ^{bus.inst[24:15], bus.inst[11:7]};

    assign is_ld   = (opcode == OP_LD);
    assign is_sd   = (opcode == OP_SD);
    assign is_r    = (opcode == OP_R);
    assign is_addi = (opcode == OP_ADDI);
    assign is_br   = (opcode == OP_BR);
    assign is_jal  = (opcode == OP_JAL);
    assign is_jalr = (opcode == OP_JALR);

    // funct3[0] separates bne from beq
    assign taken = funct3[0] ? ~bus.ALUZero : bus.ALUZero;

    always_comb begin
        r_legal = 1'b0;
        r_aop   = 3'b000;
        if (funct7 == 7'b0000000) begin
            case (funct3)
                3'b000:  begin r_legal = 1'b1; r_aop = 3'b000; end
                3'b111:  begin r_legal = 1'b1; r_aop = 3'b010; end
                3'b110:  begin r_legal = 1'b1; r_aop = 3'b011; end
                3'b100:  begin r_legal = 1'b1; r_aop = 3'b100; end
                3'b010:  begin r_legal = 1'b1; r_aop = 3'b101; end
                default: begin r_legal = 1'b0; r_aop = 3'b000; end
            endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
            r_legal = 1'b1;
            r_aop   = 3'b001;
        end
    end

    assign legal = ((is_ld || is_sd) && funct3 == 3'b011)
                || ((is_addi || is_jalr) && funct3 == 3'b000)
                || (is_br && (funct3 == 3'b000 || funct3 == 3'b001))
                || is_jal
                || (is_r && r_legal);

    // ALU/immediate selects derived once and reused in EXEC, MEM and WB so they stay stable
    always_comb begin
        alu_src   = 1'b0;
        alu_op    = 3'b000;
        inst_type = 2'b00;
        if (is_ld) begin
            alu_src = 1'b1;
        end else if (is_sd) begin
            alu_src   = 1'b1;
            inst_type = 2'b01;
        end else if (is_r) begin
            alu_op = r_aop;
        end else if (is_addi || is_jalr) begin
            alu_src = 1'b1;
        end else if (is_jal) begin
            inst_type = 2'b11;
        end else if (is_br) begin
            alu_op    = 3'b001;
            inst_type = 2'b10;
        end
    end

    always_comb begin
        state_d     = state_q;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 2'b00;
        reg_write   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_to_reg  = 2'b00;
        o_alu_src   = 1'b0;
        o_alu_op    = 3'b000;
        o_inst_type = 2'b00;
        case (state_q)
            FETCH: begin
                mem_read = 1'b1;
                if (bus.mem_ready) begin
                    ir_write = 1'b1;
                    state_d  = DECODE;
                end
            end
            DECODE: state_d = legal ? EXEC : ILLEGAL;
            EXEC: begin
                o_alu_src   = alu_src;
                o_alu_op    = alu_op;
                o_inst_type = inst_type;
                if (is_ld || is_sd) begin
                    state_d = MEM;
                end else if (is_br) begin
                    pc_write = 1'b1;
                    pc_src   = {1'b0, taken};
                    state_d  = FETCH;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                o_alu_src   = alu_src;
                o_alu_op    = alu_op;
                o_inst_type = inst_type;
                if (is_ld) begin
                    mem_read = 1'b1;
                    if (bus.mem_ready) state_d = WB;
                end else begin
                    mem_write = 1'b1;
                    if (bus.mem_ready) begin
                        pc_write = 1'b1;
                        state_d  = FETCH;
                    end
                end
            end
            WB: begin
                o_alu_src   = alu_src;
                o_alu_op    = alu_op;
                o_inst_type = inst_type;
                reg_write   = 1'b1;
                pc_write    = 1'b1;
                state_d     = FETCH;
                if (is_ld) begin
                    mem_to_reg = 2'b00;
                end else if (is_jal) begin
                    mem_to_reg = 2'b10;
                    pc_src     = 2'b01;
                end else if (is_jalr) begin
                    mem_to_reg = 2'b10;
                    pc_src     = 2'b10;
                end else begin
                    mem_to_reg = 2'b01;
                end
            end
            ILLEGAL: state_d = ILLEGAL;
            default: state_d = FETCH;
        endcase
        // reset gates every strobe so a half-finished instruction can never commit
        if (!nrst) begin
            ir_write    = 1'b0;
            pc_write    = 1'b0;
            pc_src      = 2'b00;
            reg_write   = 1'b0;
            mem_read    = 1'b0;
            mem_write   = 1'b0;
            mem_to_reg  = 2'b00;
            o_alu_src   = 1'b0;
            o_alu_op    = 3'b000;
            o_inst_type = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
            instret_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_d == ILLEGAL) illegal_q <= 1'b1;
            if (pc_write) instret_q <= instret_q + 32'd1;
        end
    end

    assign bus.IRWrite  = ir_write;
    assign bus.PCWrite  = pc_write;
    assign bus.PCsrc    = pc_src;
    assign bus.InstType = o_inst_type;
    assign bus.RegWrite = reg_write;
    assign bus.ALUsrc   = o_alu_src;
    assign bus.ALUop    = o_alu_op;
    assign bus.MemRead  = mem_read;
    assign bus.MemWrite = mem_write;
    assign bus.MemtoReg = mem_to_reg;
    assign bus.state    = state_q;
    assign bus.illegal  = illegal_q;
    assign bus.instret  = instret_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed-vector bench for multicycle_ctrl
module tb_multicycle_ctrl;
    localparam logic [31:0] I_ADD  = 32'h0020_8033;
    localparam logic [31:0] I_SUB  = 32'h4020_81B3;
    localparam logic [31:0] I_LD   = 32'h0001_3083;
    localparam logic [31:0] I_SD   = 32'h0011_3423;
    localparam logic [31:0] I_BNE  = 32'h0020_9463;
    localparam logic [31:0] I_BEQ  = 32'h0020_8463;
    localparam logic [31:0] I_JALR = 32'h0001_00E7;
    localparam logic [31:0] I_JAL  = 32'h0100_00EF;
    localparam logic [31:0] I_ADDI = 32'h0050_0093;
    localparam logic [31:0] I_BAD  = 32'h4020_F033;

    logic clk;
    logic nrst;
    int   n_vec;
    int   n_miss;
    logic [14:0] ctl;

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    assign ctl = {bus.IRWrite, bus.PCWrite, bus.PCsrc, bus.InstType, bus.RegWrite,
                  bus.ALUsrc, bus.ALUop, bus.MemRead, bus.MemWrite, bus.MemtoReg};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] cw(input logic irw, input logic pcw,
                                       input logic [1:0] pcs, input logic [1:0] it,
                                       input logic rw, input logic as,
                                       input logic [2:0] aop, input logic mr,
                                       input logic mw, input logic [1:0] m2r);
        return {irw, pcw, pcs, it, rw, as, aop, mr, mw, m2r};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic mr, input logic [2:0] st,
                        input logic [14:0] exp_cw);
        bus.mem_ready = mr;
        #1;
        check({tag, " state"}, 32'(bus.state), 32'(st));
        check({tag, " ctl"}, 32'(ctl), 32'(exp_cw));
        tick();
    endtask

    task automatic fetch_decode(input string tag);
        step({tag, " F"}, 1'b1, 3'd0, cw(1, 0, 2'b00, 2'b00, 0, 0, 3'b000, 1, 0, 2'b00));
        step({tag, " D"}, 1'b1, 3'd1, 15'd0);
    endtask

    initial begin
        n_vec         = 0;
        n_miss        = 0;
        nrst          = 1'b0;
        bus.inst      = I_ADD;
        bus.ALUZero   = 1'b0;
        bus.mem_ready = 1'b1;
        tick();
        tick();
        check("rst state", 32'(bus.state), 32'd0);
        check("rst illegal", 32'(bus.illegal), 32'd0);
        check("rst instret", bus.instret, 32'd0);
        check("rst ctl", 32'(ctl), 32'd0);
        nrst = 1'b1;

        fetch_decode("add");
        step("add E", 1'b1, 3'd2, 15'd0);
        step("add W", 1'b1, 3'd4, cw(0, 1, 2'b00, 2'b00, 1, 0, 3'b000, 0, 0, 2'b01));
        check("add instret", bus.instret, 32'd1);

        bus.inst = I_LD;
        fetch_decode("ld");
        step("ld E", 1'b1, 3'd2, cw(0, 0, 2'b00, 2'b00, 0, 1, 3'b000, 0, 0, 2'b00));
        for (int i = 0; i < 3; i++)
            step("ld M stall", 1'b0, 3'd3, cw(0, 0, 2'b00, 2'b00, 0, 1, 3'b000, 1, 0, 2'b00));
        step("ld M", 1'b1, 3'd3, cw(0, 0, 2'b00, 2'b00, 0, 1, 3'b000, 1, 0, 2'b00));
        step("ld W", 1'b1, 3'd4, cw(0, 1, 2'b00, 2'b00, 1, 1, 3'b000, 0, 0, 2'b00));
        check("ld instret", bus.instret, 32'd2);

        bus.inst = I_SD;
        step("sd F stall", 1'b0, 3'd0, cw(0, 0, 2'b00, 2'b00, 0, 0, 3'b000, 1, 0, 2'b00));
        fetch_decode("sd");
        step("sd E", 1'b1, 3'd2, cw(0, 0, 2'b00, 2'b01, 0, 1, 3'b000, 0, 0, 2'b00));
        step("sd M stall", 1'b0, 3'd3, cw(0, 0, 2'b00, 2'b01, 0, 1, 3'b000, 0, 1, 2'b00));
        step("sd M", 1'b1, 3'd3, cw(0, 1, 2'b00, 2'b01, 0, 1, 3'b000, 0, 1, 2'b00));
        check("sd instret", bus.instret, 32'd3);

        bus.inst    = I_BNE;
        bus.ALUZero = 1'b0;
        fetch_decode("bne nz");
        step("bne nz E", 1'b1, 3'd2, cw(0, 1, 2'b01, 2'b10, 0, 0, 3'b001, 0, 0, 2'b00));
        bus.ALUZero = 1'b1;
        fetch_decode("bne z");
        step("bne z E", 1'b1, 3'd2, cw(0, 1, 2'b00, 2'b10, 0, 0, 3'b001, 0, 0, 2'b00));
        bus.inst = I_BEQ;
        fetch_decode("beq z");
        step("beq z E", 1'b1, 3'd2, cw(0, 1, 2'b01, 2'b10, 0, 0, 3'b001, 0, 0, 2'b00));
        bus.ALUZero = 1'b0;
        check("br instret", bus.instret, 32'd6);
        check("br back to fetch", 32'(bus.state), 32'd0);

        bus.inst = I_JALR;
        fetch_decode("jalr");
        step("jalr E", 1'b1, 3'd2, cw(0, 0, 2'b00, 2'b00, 0, 1, 3'b000, 0, 0, 2'b00));
        step("jalr W", 1'b1, 3'd4, cw(0, 1, 2'b10, 2'b00, 1, 1, 3'b000, 0, 0, 2'b10));

        bus.inst = I_JAL;
        fetch_decode("jal");
        step("jal E", 1'b1, 3'd2, cw(0, 0, 2'b00, 2'b11, 0, 0, 3'b000, 0, 0, 2'b00));
        step("jal W", 1'b1, 3'd4, cw(0, 1, 2'b01, 2'b11, 1, 0, 3'b000, 0, 0, 2'b10));

        bus.inst = I_ADDI;
        fetch_decode("addi");
        step("addi E", 1'b1, 3'd2, cw(0, 0, 2'b00, 2'b00, 0, 1, 3'b000, 0, 0, 2'b00));
        step("addi W", 1'b1, 3'd4, cw(0, 1, 2'b00, 2'b00, 1, 1, 3'b000, 0, 0, 2'b01));

        bus.inst = I_SUB;
        fetch_decode("sub");
        step("sub E", 1'b1, 3'd2, cw(0, 0, 2'b00, 2'b00, 0, 0, 3'b001, 0, 0, 2'b00));
        step("sub W", 1'b1, 3'd4, cw(0, 1, 2'b00, 2'b00, 1, 0, 3'b001, 0, 0, 2'b01));
        check("mix instret", bus.instret, 32'd10);

        // park in FETCH and preload the retire counter just below wrap
        bus.mem_ready = 1'b0;
        #1;
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        #1;
        check("wrap preload", bus.instret, 32'hFFFF_FFFF);
        tick();
        bus.inst = I_ADD;
        fetch_decode("wrap add");
        step("wrap add E", 1'b1, 3'd2, 15'd0);
        step("wrap add W", 1'b1, 3'd4, cw(0, 1, 2'b00, 2'b00, 1, 0, 3'b000, 0, 0, 2'b01));
        check("wrap instret", bus.instret, 32'd0);

        bus.inst = I_LD;
        fetch_decode("rst ld");
        step("rst ld E", 1'b1, 3'd2, cw(0, 0, 2'b00, 2'b00, 0, 1, 3'b000, 0, 0, 2'b00));
        step("rst ld M", 1'b0, 3'd3, cw(0, 0, 2'b00, 2'b00, 0, 1, 3'b000, 1, 0, 2'b00));
        nrst = 1'b0;
        bus.mem_ready = 1'b1;
        #1;
        check("rst mid ctl", 32'(ctl), 32'd0);
        tick();
        check("rst mid state", 32'(bus.state), 32'd0);
        check("rst mid instret", bus.instret, 32'd0);
        nrst = 1'b1;

        bus.inst = I_BAD;
        fetch_decode("bad");
        for (int i = 0; i < 10; i++) begin
            bus.ALUZero = i[0];
            check("ill flag", 32'(bus.illegal), 32'd1);
            step("ill hold", i[1], 3'd7, 15'd0);
        end
        nrst = 1'b0;
        tick();
        check("ill rst state", 32'(bus.state), 32'd0);
        check("ill rst flag", 32'(bus.illegal), 32'd0);
        nrst = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have a parameter FIELD_OPCODES (default: the RV64 subset encodings ld 0000011, sd 0100011, R 0110011, addi 0010011, branch 1100011, jal 1101111, jalr 1100111), defining the recognised opcodes.
REQ-002 The block SHALL have these ports:
  clk  input  1  rising-edge clock.
  nrst  input  1  reset, synchronous, active-low.
  inst  input  32  instruction register contents.
  ALUZero  input  1  ALU zero flag.
  mem_ready  input  1  memory handshake, request completes in the cycle it is 1.
  IRWrite  output  1  load instruction register.
  PCWrite  output  1  load PC.
  PCsrc  output  2  00 PC+4, 01 PC+imm, 10 ALU result.
  InstType  output  2  immediate format: 00 I, 01 S, 10 B, 11 J.
  RegWrite  output  1  register file write.
  ALUsrc  output  1  0 rs2, 1 immediate.
  ALUop  output  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
  MemRead  output  1  memory read request.
  MemWrite  output  1  memory write request.
  MemtoReg  output  2  00 memory, 01 ALU, 10 PC+4.
  state  output  3  current FSM state.
  illegal  output  1  sticky illegal-instruction flag.
  instret  output  32  retired-instruction counter.

Function
REQ-003 The FSM states SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4 and ILLEGAL=7; all outputs SHALL be Moore/decoded combinationally from state, inst, ALUZero and mem_ready.
REQ-004 FETCH SHALL assert MemRead and hold while mem_ready=0; when mem_ready=1 it SHALL assert IRWrite for one cycle and go to DECODE.
REQ-005 DECODE SHALL go to EXEC for a legal instruction, and to ILLEGAL otherwise.
  Legal instructions: ld/sd with funct3=011; addi and jalr with funct3=000; branch with funct3 000/001; jal; R-type with funct7=0000000 and funct3 in {000, 111, 110, 100, 010}, or funct7=0100000 with funct3=000.
REQ-006 EXEC SHALL drive ALUsrc, ALUop and InstType per opcode, then transition as follows:
  - ld/sd: ALUsrc=1, ALUop=000, next state MEM.
  - R-type: ALUsrc=0, ALUop from funct, next state WB.
  - addi/jalr: ALUsrc=1, ALUop=000, next state WB.
  - jal: next state WB.
  - branch: ALUop=001, InstType=10, PCWrite=1, PCsrc={0,taken}, next state FETCH.
REQ-007 The branch taken signal SHALL be ALUZero for beq and ~ALUZero for bne.
REQ-008 MEM SHALL hold ALUsrc=1, ALUop=000 and InstType (00 for ld, 01 for sd) stable.
  - ld: MemRead=1; stall until mem_ready, then go to WB.
  - sd: MemWrite=1; stall until mem_ready, then assert PCWrite with PCsrc=00 in the same cycle and go to FETCH.
REQ-009 WB SHALL assert RegWrite and PCWrite for exactly one cycle, then go to FETCH, with:
  - ld: MemtoReg=00, PCsrc=00.
  - R/addi: MemtoReg=01, PCsrc=00.
  - jal: MemtoReg=10, PCsrc=01, InstType=11.
  - jalr: MemtoReg=10, PCsrc=10, ALUsrc=1, ALUop=000.
REQ-010 In WB and MEM, the ALU controls SHALL be held at their EXEC values.
REQ-011 Outputs not listed for a state SHALL be 0.
REQ-012 MemRead and MemWrite SHALL never be asserted together.
REQ-013 instret SHALL increment by 1 on every cycle with PCWrite=1, wrapping from 0xFFFFFFFF to 0.
REQ-014 ILLEGAL SHALL set illegal=1, force all strobes to 0, and remain in ILLEGAL until reset.
REQ-015 Latency with mem_ready tied to 1 SHALL be: branch 3 cycles; R-type, addi, jal, jalr and sd 4 cycles; ld 5 cycles.

Reset
REQ-016 While nrst=0 at a clock edge, the block SHALL set state=FETCH, illegal=0 and instret=0.
REQ-017 While nrst=0, all strobe and select outputs SHALL be driven 0 combinationally.
REQ-018 Reset asserted mid-instruction (including during a MEM stall) SHALL abandon the instruction with no RegWrite or PCWrite.

Verification
REQ-019 add (0x00208033), mem_ready=1: FETCH→DECODE→EXEC→WB; WB has RegWrite=1, MemtoReg=01, PCWrite=1, PCsrc=00, ALUop=000; instret 0→1.
REQ-020 ld, mem_ready low 3 cycles in MEM: MemRead held 3 cycles, WB has MemtoReg=00, total 8 cycles, with no PCWrite before WB.
REQ-021 bne with ALUZero=0: EXEC has PCWrite=1, PCsrc=01, back to FETCH; same with ALUZero=1 gives PCsrc=00.
REQ-022 jalr: WB has RegWrite=1, MemtoReg=10, PCsrc=10, ALUsrc=1; jal: WB has PCsrc=01, InstType=11.
REQ-023 R-type with funct7=0100000 and funct3=111: DECODE→ILLEGAL, illegal=1, all strobes 0 for 10 cycles, then nrst=0 for 1 edge → state=0, illegal=0.
REQ-024 Preload instret=0xFFFFFFFF via 2^32-1 retires (or forced): the next retire gives instret=0.
